// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package seg_scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam int unsigned DEF_REFRESH_DIV  = 16;
  localparam int unsigned DEF_BLANK_CYC    = 2;
  localparam int unsigned DEF_BLINK_FRAMES = 4;

  function automatic logic [3:0] an_select(input logic [1:0] digit);
    an_select = ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot cycle counter; flags the last blank cycle, the last two cycles and the slot end.
module slot_timer
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic clear,
  input  logic i_run,
  output logic o_blank_done,
  output logic o_pre_done,
  output logic o_slot_done
);

  localparam logic [15:0] CNT_LAST   = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] CNT_PRE    = 16'(REFRESH_DIV - 2);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  logic [15:0] r_cnt;

  // Counter sits at zero while the scan is idle so the first slot always starts fresh.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_cnt <= 16'd0;
    end else if (!i_run) begin
      r_cnt <= 16'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_blank_done = (r_cnt == BLANK_LAST);
  assign o_pre_done   = (r_cnt == CNT_PRE);
  assign o_slot_done  = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scanner with ghost-guard blanking, frame-coherent snapshot and done blinking.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYC    = DEF_BLANK_CYC,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic       done_in,
  input  logic [7:0] LED0,
  input  logic [7:0] LED1,
  input  logic [7:0] LED2,
  input  logic [7:0] LED3,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam logic [8:0] BLINK_ON   = 9'(BLINK_FRAMES);
  localparam logic [8:0] BLINK_LAST = 9'(2 * BLINK_FRAMES - 1);

  scan_state_t      r_state;
  logic [1:0]       r_digit;
  logic [8:0]       r_blink_cnt;
  logic             r_blink_act;
  logic [3:0][7:0]  r_snap;

  logic w_run;
  logic w_blank_done;
  logic w_pre_done;
  logic w_slot_done;
  logic w_blink_off;

  assign w_run       = en && (r_state != IDLE);
  assign w_blink_off = r_blink_act && (r_blink_cnt >= BLINK_ON);

  slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_slot_timer (
    .clk          (clk),
    .clear        (clear),
    .i_run        (w_run),
    .o_blank_done (w_blank_done),
    .o_pre_done   (w_pre_done),
    .o_slot_done  (w_slot_done)
  );

  // Outputs are loaded on the same edge as the state they belong to, so they never lag the FSM.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= IDLE;
      r_digit     <= 2'd0;
      r_blink_cnt <= 9'd0;
      r_blink_act <= 1'b0;
      r_snap      <= {4{SEG_BLANK}};
      seg_out     <= SEG_BLANK;
      an_out      <= AN_OFF;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_digit <= 2'd0;
        seg_out <= SEG_BLANK;
        an_out  <= AN_OFF;
      end else begin
        case (r_state)
          IDLE: begin
            r_state     <= BLANK;
            r_digit     <= 2'd0;
            r_snap      <= {LED3, LED2, LED1, LED0};
            r_blink_cnt <= 9'd0;
            r_blink_act <= done_in;
            seg_out     <= SEG_BLANK;
            an_out      <= AN_OFF;
          end
          BLANK: begin
            if (w_blank_done) begin
              r_state <= SHOW;
              seg_out <= w_blink_off ? SEG_BLANK : r_snap[r_digit];
              an_out  <= w_blink_off ? AN_OFF : an_select(r_digit);
            end else begin
              seg_out <= SEG_BLANK;
              an_out  <= AN_OFF;
            end
          end
          SHOW: begin
            if (w_slot_done) begin
              r_state <= BLANK;
              r_digit <= r_digit + 2'd1;
              seg_out <= SEG_BLANK;
              an_out  <= AN_OFF;
              // Leaving digit 3 starts a new frame: resample LEDs and the blink phase together.
              if (r_digit == 2'd3) begin
                r_snap      <= {LED3, LED2, LED1, LED0};
                r_blink_act <= done_in;
                if (done_in && r_blink_act) begin
                  r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? 9'd0 : r_blink_cnt + 9'd1;
                end else begin
                  r_blink_cnt <= 9'd0;
                end
              end
            end else begin
              frame_tick <= (r_digit == 2'd3) && w_pre_done;
            end
          end
          default: begin
            r_state <= IDLE;
            r_digit <= 2'd0;
            seg_out <= SEG_BLANK;
            an_out  <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_seg_scan_mux;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    bit         chk_seg;
    bit         tick;
  } exp_t;

  logic       clk;
  logic       clear;
  logic       en;
  logic       done_in;
  logic [7:0] LED0, LED1, LED2, LED3;
  logic [7:0] seg_out;
  logic [3:0] an_out;
  logic       frame_tick;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;
  logic prev_tick = 1'b0;

  seg_scan_mux dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .done_in    (done_in),
    .LED0       (LED0),
    .LED1       (LED1),
    .LED2       (LED2),
    .LED3       (LED3),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    n_total = n_total + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  // Monitor: compares every queued expectation at its cycle, plus the anode/tick invariants.
  always @(negedge clk) begin
    check("an_onehot0", cyc, 32'($countones(~an_out) <= 1), 32'd1);
    check("tick_not_double", cyc, 32'(frame_tick && prev_tick), 32'd0);
    prev_tick = frame_tick;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        check("exp_missed", e.cyc, 32'(cyc), 32'(e.cyc));
      end else begin
        check("an_out", cyc, 32'(an_out), 32'(e.an));
        if (e.chk_seg) check("seg_out", cyc, 32'(seg_out), 32'(e.seg));
        check("frame_tick", cyc, 32'(frame_tick), 32'(e.tick));
      end
    end
  end

  task automatic push_blank(input int from, input int to);
    exp_t x;
    for (int c = from; c <= to; c++) begin
      x.cyc = c; x.an = 4'b1111; x.seg = 8'hFF; x.chk_seg = 1'b1; x.tick = 1'b0;
      q.push_back(x);
    end
  endtask

  // One frame of 4 slots x 16 cycles: 2 blank cycles then 14 show cycles per digit.
  task automatic push_frame(input int start, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input bit vis, input int upto);
    exp_t x;
    logic [7:0] segs [4];
    int slot, pos;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = 1; k <= upto; k++) begin
      slot = (k - 1) / 16;
      pos  = (k - 1) % 16;
      x.cyc = start + k - 1;
      x.tick = (k == 64);
      if (pos < 2) begin
        x.an = 4'b1111; x.seg = 8'hFF; x.chk_seg = 1'b1;
      end else if (vis) begin
        x.an = ~(4'b0001 << slot); x.seg = segs[slot]; x.chk_seg = 1'b1;
      end else begin
        x.an = 4'b1111; x.seg = 8'hFF; x.chk_seg = 1'b0;
      end
      q.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; done_in = 1'b0;
    LED0 = 8'hFF; LED1 = 8'hFF; LED2 = 8'hFF; LED3 = 8'hFF;
    push_blank(1, 6);

    wait_cyc(3);
    clear = 1'b0;
    wait_cyc(6);
    LED0 = 8'hC0; LED1 = 8'hF9; LED2 = 8'hA4; LED3 = 8'hB0;
    en = 1'b1;
    push_frame(7,   8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b1, 64);
    push_frame(71,  8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b1, 64);
    push_frame(135, 8'hC0, 8'hF9, 8'h99, 8'hB0, 1'b1, 64);
    push_frame(199, 8'hC0, 8'hF9, 8'h99, 8'hB0, 1'b1, 20);

    // Mid-frame LED change at frame-1 cycle 40 must wait for frame 2.
    wait_cyc(110);
    LED2 = 8'h99;

    // Drop en during digit-1 SHOW of frame 3.
    wait_cyc(218);
    en = 1'b0;
    push_blank(219, 222);

    wait_cyc(222);
    en = 1'b1;
    done_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_frame(223 + 64 * i, 8'hC0, 8'hF9, 8'h99, 8'hB0, (i % 8) < 4, 64);
    end
    push_frame(799, 8'hC0, 8'hF9, 8'h99, 8'hB0, 1'b1, 10);

    // Asynchronous clear between edges during digit-0 SHOW.
    wait_cyc(808);
    #2;
    clear = 1'b1;
    en = 1'b0;
    #1;
    check("clr_async_an", cyc, 32'(an_out), 32'h0000000F);
    check("clr_async_seg", cyc, 32'(seg_out), 32'h000000FF);
    check("clr_async_tick", cyc, 32'(frame_tick), 32'd0);
    push_blank(809, 814);

    wait_cyc(810);
    clear = 1'b0;
    wait_cyc(814);
    done_in = 1'b0;
    LED0 = 8'h92; LED1 = 8'h82; LED2 = 8'hF8; LED3 = 8'h7F;
    en = 1'b1;
    push_frame(815, 8'h92, 8'h82, 8'hF8, 8'h7F, 1'b1, 64);

    wait_cyc(815 + 64 + 1);
    check("queue_drained", cyc, 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
